// File: rtl/sram_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 16-bit words, writes them
// to external SRAM, verifies an 8-bit checksum, then pulses load to hand over execution.
module sram_boot_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  start_page,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DOUT,
    output logic        SRAM_WE_N,
    output logic [15:0] sram_addr,
    output logic        load,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, CSUM, GO, DONE, ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  page_reg;
    logic [7:0]  lo_reg;
    logic [7:0]  sum_reg;
    logic [15:0] count_reg;
    logic [15:0] index_reg;
    logic [15:0] index_inc;
    logic        xfer;
    logic        accept_start;
    logic        ready_next, we_n_next, load_next, busy_next, done_next;

    assign xfer         = rx_valid && rx_ready;
    assign accept_start = (state_reg == IDLE) && start;
    assign index_inc    = index_reg + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start) state_next = CNT_LO;
            CNT_LO: if (xfer) state_next = CNT_HI;
            CNT_HI: if (xfer) state_next = ({rx_data, count_reg[7:0]} == 16'd0) ? CSUM : DAT_LO;
            DAT_LO: if (xfer) state_next = DAT_HI;
            DAT_HI: if (xfer) state_next = WRITE;
            WRITE:  state_next = (index_inc == count_reg) ? CSUM : DAT_LO;
            CSUM:   if (xfer) state_next = (rx_data == sum_reg) ? GO : ERR;
            GO:     state_next = DONE;
            DONE:   state_next = DONE;
            ERR:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_comb begin
        ready_next = 1'b0;
        we_n_next  = 1'b1;
        load_next  = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_next)
            CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM: begin
                ready_next = 1'b1;
                busy_next  = 1'b1;
            end
            WRITE: begin
                we_n_next = 1'b0;
                busy_next = 1'b1;
            end
            GO: begin
                load_next = 1'b1;
                busy_next = 1'b1;
            end
            DONE: done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready  <= 1'b0;
            SRAM_WE_N <= 1'b1;
            load      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_ready  <= ready_next;
            SRAM_WE_N <= we_n_next;
            load      <= load_next;
            busy      <= busy_next;
            done      <= done_next;
            if (accept_start)
                error <= 1'b0;
            else if (state_next == ERR)
                error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_reg  <= 8'h00;
            lo_reg    <= 8'h00;
            sum_reg   <= 8'h00;
            count_reg <= 16'h0000;
            index_reg <= 16'h0000;
            SRAM_ADDR <= 16'h0000;
            SRAM_DOUT <= 16'h0000;
            sram_addr <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    page_reg  <= start_page;
                    index_reg <= 16'h0000;
                    sum_reg   <= 8'h00;
                    sram_addr <= {start_page, 8'h00};
                end
                CNT_LO: if (xfer) count_reg[7:0]  <= rx_data;
                CNT_HI: if (xfer) count_reg[15:8] <= rx_data;
                DAT_LO: if (xfer) begin
                    lo_reg  <= rx_data;
                    sum_reg <= sum_reg + rx_data;
                end
                DAT_HI: if (xfer) begin
                    sum_reg   <= sum_reg + rx_data;
                    SRAM_DOUT <= {rx_data, lo_reg};
                    // 16-bit add: pages near the top of memory wrap to 0x0000.
                    SRAM_ADDR <= {page_reg, 8'h00} + index_reg;
                end
                WRITE: index_reg <= index_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_boot_loader.sv
// Directed bench for sram_boot_loader: feeds byte streams, captures every SRAM write
// and checks handshake, write contents, load/done/error and reset behaviour.
module tb_sram_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_page = 8'h00;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] SRAM_ADDR;
    logic [15:0] SRAM_DOUT;
    logic        SRAM_WE_N;
    logic [15:0] sram_addr;
    logic        load;
    logic        busy;
    logic        done;
    logic        error;

    sram_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_page (start_page),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DOUT  (SRAM_DOUT),
        .SRAM_WE_N  (SRAM_WE_N),
        .sram_addr  (sram_addr),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] exp_words[$];
    logic [7:0]  stream[$];
    logic        prev_we_low = 1'b0;

    // Capture every write cycle; the port must be idle on rx and a write never lasts two cycles.
    always @(negedge clk) begin
        if (rst_n && !SRAM_WE_N) begin
            wr_addr_q.push_back(SRAM_ADDR);
            wr_data_q.push_back(SRAM_DOUT);
            check("ready_in_write", {31'd0, rx_ready}, 32'd0);
            check("we_single_cycle", {31'd0, prev_we_low}, 32'd0);
        end
        prev_we_low = rst_n && !SRAM_WE_N;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic make_stream(input logic [7:0] csum_xor);
        logic [7:0]  s;
        logic [15:0] n16;
        int n;
        s = 8'h00;
        n = exp_words.size();
        n16 = n[15:0];
        stream = {};
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        foreach (exp_words[i]) begin
            logic [15:0] w;
            w = exp_words[i];
            stream.push_back(w[7:0]);
            stream.push_back(w[15:8]);
            s = s + w[7:0] + w[15:8];
        end
        stream.push_back(s ^ csum_xor);
    endtask

    // Entered and left on a negedge; rx_ready seen at a negedge decides the next posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (rx_ready) ok = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) check("rx_timeout", 32'd0, 32'd1);
    endtask

    task automatic begin_session(input logic [7:0] page);
        wr_addr_q = {};
        wr_data_q = {};
        start_page = page;
        start = 1'b1;
        @(negedge clk);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, rx_ready}, 32'd1);
        check("start_error_clr", {31'd0, error}, 32'd0);
        check("start_run_page", {16'd0, sram_addr}, {16'd0, page, 8'h00});
    endtask

    task automatic run_stream(input logic [7:0] page, input bit gaps);
        begin_session(page);
        for (int i = 0; i < stream.size(); i++)
            send_byte(stream[i], gaps ? (i % 4) : 0);
    endtask

    task automatic check_writes(input logic [7:0] page);
        logic [15:0] base;
        int n;
        base = {page, 8'h00};
        n = exp_words.size();
        check("write_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            logic [15:0] ea;
            ea = base + 16'(i);
            check("write_addr", {16'd0, wr_addr_q[i]}, {16'd0, ea});
            check("write_data", {16'd0, wr_data_q[i]}, {16'd0, exp_words[i]});
        end
    endtask

    task automatic finish_ok(input string name, input logic [7:0] page);
        check("load_pulse", {31'd0, load}, 32'd1);
        check("no_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("load_one_cycle", {31'd0, load}, 32'd0);
        check("done_set", {31'd0, done}, 32'd1);
        check("busy_clear", {31'd0, busy}, 32'd0);
        check("done_ready_low", {31'd0, rx_ready}, 32'd0);
        check("run_page", {16'd0, sram_addr}, {16'd0, page, 8'h00});
        check_writes(page);
        $display("session %s page=%02h words=%0d writes=%0d done=%0d", name, page,
                 exp_words.size(), wr_addr_q.size(), done);
    endtask

    initial begin
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_addr", {16'd0, SRAM_ADDR}, 32'd0);
        check("rst_dout", {16'd0, SRAM_DOUT}, 32'd0);
        check("rst_run_page", {16'd0, sram_addr}, 32'd0);
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        do_reset();

        // Basic two-word load with hand-computed checksum 0x14.
        exp_words = '{16'h1234, 16'h5678};
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        run_stream(8'h12, 1'b0);
        finish_ok("basic", 8'h12);
        check("basic_w0_addr", {16'd0, wr_addr_q[0]}, 32'h1200);
        check("basic_w1_addr", {16'd0, wr_addr_q[1]}, 32'h1201);
        check("basic_w1_data", {16'd0, wr_data_q[1]}, 32'h5678);

        // Bad checksum, then retry after dropping start.
        do_reset();
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h15};
        run_stream(8'h12, 1'b0);
        check("bad_no_load", {31'd0, load}, 32'd0);
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        check("bad_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        check("bad_done", {31'd0, done}, 32'd0);
        check_writes(8'h12);
        $display("session bad_csum page=12 writes=%0d error=%0d", wr_addr_q.size(), error);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("error_sticky", {31'd0, error}, 32'd1);
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        run_stream(8'h12, 1'b0);
        finish_ok("retry", 8'h12);

        // Empty program.
        do_reset();
        exp_words = {};
        stream = '{8'h00, 8'h00, 8'h00};
        run_stream(8'h30, 1'b0);
        finish_ok("empty", 8'h30);

        // 16 words with rx_valid gaps.
        do_reset();
        exp_words = {};
        for (int i = 0; i < 16; i++) exp_words.push_back(16'(i) * 16'h1357 + 16'h0042);
        make_stream(8'h00);
        run_stream(8'h40, 1'b1);
        finish_ok("gaps16", 8'h40);

        // Address wrap from page 0xFF.
        do_reset();
        exp_words = {};
        for (int i = 0; i < 258; i++) exp_words.push_back(16'(i) ^ 16'hC3A5);
        make_stream(8'h00);
        run_stream(8'hFF, 1'b0);
        finish_ok("wrap258", 8'hFF);
        if (wr_addr_q.size() >= 258) begin
            check("wrap_addr_256", {16'd0, wr_addr_q[256]}, 32'h0000);
            check("wrap_addr_257", {16'd0, wr_addr_q[257]}, 32'h0001);
        end else begin
            check("wrap_count", wr_addr_q.size(), 258);
        end

        // Reset while the second word's high byte is pending.
        do_reset();
        exp_words = '{16'hBEEF, 16'hCAFE};
        make_stream(8'h00);
        begin_session(8'h55);
        for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
        check("pre_rst_addr", {16'd0, SRAM_ADDR}, 32'h5500);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("mid_rst_addr", {16'd0, SRAM_ADDR}, 32'd0);
        check("mid_rst_dout", {16'd0, SRAM_DOUT}, 32'd0);
        check("mid_rst_run_page", {16'd0, sram_addr}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_load", {31'd0, load}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_error", {31'd0, error}, 32'd0);
        $display("session reset_abort page=55 busy=%0d", busy);
        do_reset();
        run_stream(8'h55, 1'b0);
        finish_ok("after_reset", 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_boot_loader.md
# sram_boot_loader

Boot-time program loader that receives a byte stream from the I/O path (UART receiver or equivalent), assembles 16-bit instruction words and writes them into external SRAM. It then hands execution over by pulsing `load` to the boot/run switch and publishing the SRAM page to run from. It owns the SRAM write port from `start` until completion; after `done` the CPU instruction-fetch path owns SRAM.

## Interface
Parameters:
- none; all widths are fixed: 8-bit stream, 16-bit SRAM word and address.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; arms a load session when sampled high in IDLE.
- `start_page` in 8: SRAM page (address bits 15:8) to load into; latched when `start` is accepted.
- `rx_data` in 8: incoming stream byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader accepts the byte this cycle. A transfer occurs when `rx_valid && rx_ready`.
- `SRAM_ADDR` out 16: SRAM write address.
- `SRAM_DOUT` out 16: SRAM write data.
- `SRAM_WE_N` out 1: SRAM write enable, active low.
- `sram_addr` out 16: run page for the boot/run switch, `{page,8'h00}`.
- `load` out 1: one-cycle pulse that switches to run mode.
- `busy` out 1: session in progress (CNT_LO through GO).
- `done` out 1: sticky; load completed successfully.
- `error` out 1: sticky; checksum mismatch.

## Operation
- Stream format: count_lo, count_hi (N words, 16-bit little-endian), then N × {data_lo, data_hi}, then 1 checksum byte.
- Checksum is the 8-bit modulo-256 sum of the 2N data bytes only. Count bytes are not included.
- States: IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, CSUM, GO, DONE, ERR.
- IDLE → CNT_LO when `start`=1. This edge latches `page=start_page`, clears the word index, and clears the running sum.
- CNT_LO / CNT_HI: each state accepts one byte into the count.
  - After CNT_HI: go to CSUM if N==0, else DAT_LO.
- DAT_LO: accept the low byte, add it to the sum, go to DAT_HI.
- DAT_HI: accept the high byte, add it to the sum. On the same edge:
  - `SRAM_DOUT={hi,lo}`
  - `SRAM_ADDR={page,8'h00}+index`, a 16-bit add that wraps 0xFFFF→0x0000
  - then go to WRITE.
- WRITE: `SRAM_WE_N`=0 for exactly one cycle with address and data stable. `rx_ready`=0.
  - Exit: index+1; go to CSUM if index+1==N, else DAT_LO.
- CSUM: accept one byte.
  - Equal to sum → GO.
  - Otherwise → ERR.
- GO: `load`=1 for one cycle, then DONE.
- DONE: `done`=1; `rx_ready`=0; `start` is ignored. Terminal until reset.
- ERR: `error`=1; `rx_ready`=0. Returns to IDLE when `start`=0, so the host can retry by re-asserting `start`. `error` clears on the next accepted `start`.
- `rx_ready`=1 only in CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM.
- `sram_addr={page,8'h00}` is valid from CNT_LO onward and is held in DONE.

## Timing
- Reset values: `rx_ready`=0, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DOUT`=0, `sram_addr`=0, `load`=0, `busy`=0, `done`=0, `error`=0; state=IDLE.
- Reset mid-session aborts immediately. SRAM contents are not guaranteed, and `SRAM_WE_N` returns to 1 asynchronously.
- Throughput: with `rx_valid` held high, each word costs 3 cycles (lo, hi, WRITE).
- Minimum session length: 2 + 3N + 1 (CSUM) + 1 (GO) cycles after `start` acceptance.
- `load` rises the cycle after the checksum byte is accepted.
- `rx_valid` low stalls in the current state with no side effects. Bytes offered while `rx_ready`=0 are not consumed.
- N=65535 is legal. Address wraps per the rule above.
- All outputs are registered.

## Test plan
- `start_page`=0x12, stream 02 00 34 12 78 56 14 → writes 0x1234@0x1200 and 0x5678@0x1201. Exactly 2 one-cycle WE_N lows, then `load` pulse, `done`=1, `sram_addr`=0x1200.
- Same stream with last byte 0x15 → both writes occur, no `load`, `error`=1. Drop `start`, re-run with the correct stream → `error` clears, `done`=1.
- Count 00 00, checksum 00 → no WE_N activity, `load` pulses, `done`=1.
- Random `rx_valid` gaps over a 16-word load → identical SRAM writes, WE_N only in WRITE, `rx_ready`=0 during WRITE.
- `start_page`=0xFF, N=258 → last two writes at 0x0000 and 0x0001 (wrap).
- Assert `rst_n`=0 during DAT_HI → all outputs at reset values immediately. A subsequent full session succeeds.
